// File: rtl/rd_pixel_stream_pkg.sv
// Shared constants for the AXI read-beat to pixel-stream converter.
package rd_pixel_stream_pkg;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    // Each read beat carries exactly two pixels.
    localparam int unsigned PIX_PER_BEAT = 2;

    // Bits needed to hold values 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rd_beat_fifo.sv
// Synchronous beat FIFO with registered read data and a registered ready flag.
module rd_beat_fifo
    import rd_pixel_stream_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    output logic         ready,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         not_empty
);

    localparam int AW = cnt_width(DEPTH);
    localparam int CW = cnt_width(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  pop_data_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          ready_reg;
    logic          do_push;
    logic          do_pop;

    assign do_push   = push && ready_reg;
    assign do_pop    = pop && not_empty;
    assign not_empty = (count_reg != '0);
    assign ready     = ready_reg;
    assign pop_data  = pop_data_reg;

    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Storage and read register carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
        if (do_pop) begin
            pop_data_reg <= mem[rd_ptr_reg];
        end
    end

    // ready is low in reset and rises on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            ready_reg  <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            ready_reg <= (count_next != FULL_COUNT);
        end
    end

endmodule

// File: rtl/rd_pixel_stream.sv
// Converts AXI read-data beats into an AXI-Stream video pixel stream with
// start-of-frame / end-of-line framing, frame-done pulse and error tracking.
module rd_pixel_stream
    import rd_pixel_stream_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int PIX_W       = 16,
    parameter int FIFO_DEPTH  = 16,
    parameter int LINE_PIX    = 640,
    parameter int FRAME_LINES = 480
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [DATA_W-1:0] S_RDATA,
    input  logic [1:0]        S_RRESP,
    input  logic              S_RLAST,
    input  logic              S_RVALID,
    output logic              S_RREADY,
    output logic [PIX_W-1:0]  M_TDATA,
    output logic              M_TUSER,
    output logic              M_TLAST,
    output logic              M_TVALID,
    input  logic              M_TREADY,
    output logic              FRAME_DONE,
    output logic              RESP_ERR,
    output logic [15:0]       BURST_CNT
);

    localparam int XW = cnt_width(LINE_PIX);
    localparam int YW = cnt_width(FRAME_LINES);

    logic              fifo_ready;
    logic              fifo_not_empty;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_data;
    logic              beat_acc;
    logic              fetch_reg;
    logic [DATA_W-1:0] stage_reg;
    logic              stage_valid_reg;
    logic              half_reg;
    logic [XW-1:0]     x_reg;
    logic [YW-1:0]     y_reg;
    logic              pix_hs;
    logic              line_end;
    logic              frame_end;
    logic              frame_done_reg;
    logic              resp_err_reg;
    logic [15:0]       burst_cnt_reg;
    logic [PIX_W-1:0]  halves [PIX_PER_BEAT];

    rd_beat_fifo #(
        .W     (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (ACLK),
        .rst       (ARESET),
        .push      (S_RVALID),
        .push_data (S_RDATA),
        .ready     (fifo_ready),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .not_empty (fifo_not_empty)
    );

    assign S_RREADY  = fifo_ready;
    assign beat_acc  = S_RVALID && fifo_ready;
    assign pix_hs    = stage_valid_reg && M_TREADY;
    assign line_end  = (x_reg == XW'(LINE_PIX - 1));
    assign frame_end = line_end && (y_reg == YW'(FRAME_LINES - 1));

    // A fetch is in flight for one cycle (registered RAM read), so only one
    // may be outstanding and only when the stage is, or is becoming, free.
    assign fifo_pop = fifo_not_empty && !fetch_reg &&
                      (!stage_valid_reg || (pix_hs && half_reg));

    for (genvar gi = 0; gi < PIX_PER_BEAT; gi++) begin : g_half
        assign halves[gi] = stage_reg[gi*PIX_W +: PIX_W];
    end

    assign M_TDATA    = halves[half_reg];
    assign M_TVALID   = stage_valid_reg;
    assign M_TUSER    = stage_valid_reg && (x_reg == '0) && (y_reg == '0);
    assign M_TLAST    = stage_valid_reg && line_end;
    assign FRAME_DONE = frame_done_reg;
    assign RESP_ERR   = resp_err_reg;
    assign BURST_CNT  = burst_cnt_reg;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            fetch_reg       <= 1'b0;
            stage_reg       <= '0;
            stage_valid_reg <= 1'b0;
            half_reg        <= 1'b0;
        end else begin
            fetch_reg <= fifo_pop;
            if (fetch_reg) begin
                stage_reg       <= fifo_data;
                stage_valid_reg <= 1'b1;
                half_reg        <= 1'b0;
            end else if (pix_hs) begin
                if (half_reg) begin
                    stage_valid_reg <= 1'b0;
                    half_reg        <= 1'b0;
                end else begin
                    half_reg <= 1'b1;
                end
            end
        end
    end

    // Raster position of the pixel currently presented; RLAST plays no part.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            x_reg          <= '0;
            y_reg          <= '0;
            frame_done_reg <= 1'b0;
            resp_err_reg   <= 1'b0;
            burst_cnt_reg  <= '0;
        end else begin
            if (pix_hs) begin
                if (line_end) begin
                    x_reg <= '0;
                    y_reg <= frame_end ? '0 : y_reg + 1'b1;
                end else begin
                    x_reg <= x_reg + 1'b1;
                end
            end
            frame_done_reg <= pix_hs && frame_end;
            if (beat_acc && (S_RRESP != RRESP_OKAY)) begin
                resp_err_reg <= 1'b1;
            end
            if (beat_acc && S_RLAST) begin
                burst_cnt_reg <= burst_cnt_reg + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rd_pixel_stream.sv
// Self-checking bench: queue-based raster model plus directed and random stimulus.
module tb_rd_pixel_stream;

    localparam int LINE_PIX    = 4;
    localparam int FRAME_LINES = 2;
    localparam int FIFO_DEPTH  = 4;

    typedef struct packed {
        logic [15:0] data;
        logic        user;
        logic        last;
        logic        fend;
    } pix_t;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b0;
    logic [31:0] S_RDATA;
    logic [1:0]  S_RRESP;
    logic        S_RLAST;
    logic        S_RVALID;
    logic        S_RREADY;
    logic [15:0] M_TDATA;
    logic        M_TUSER;
    logic        M_TLAST;
    logic        M_TVALID;
    logic        M_TREADY;
    logic        FRAME_DONE;
    logic        RESP_ERR;
    logic [15:0] BURST_CNT;

    rd_pixel_stream #(
        .DATA_W      (32),
        .PIX_W       (16),
        .FIFO_DEPTH  (FIFO_DEPTH),
        .LINE_PIX    (LINE_PIX),
        .FRAME_LINES (FRAME_LINES)
    ) dut (
        .ACLK       (ACLK),
        .ARESET     (ARESET),
        .S_RDATA    (S_RDATA),
        .S_RRESP    (S_RRESP),
        .S_RLAST    (S_RLAST),
        .S_RVALID   (S_RVALID),
        .S_RREADY   (S_RREADY),
        .M_TDATA    (M_TDATA),
        .M_TUSER    (M_TUSER),
        .M_TLAST    (M_TLAST),
        .M_TVALID   (M_TVALID),
        .M_TREADY   (M_TREADY),
        .FRAME_DONE (FRAME_DONE),
        .RESP_ERR   (RESP_ERR),
        .BURST_CNT  (BURST_CNT)
    );

    always #5 ACLK = ~ACLK;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   first_acc_cyc = -1;
    int   first_val_cyc = -1;
    int   fd_count = 0;
    int   k_model = 0;
    pix_t exp_q[$];
    pix_t got[$];
    pix_t cur;
    pix_t hold_pix;
    logic hold_valid = 1'b0;
    logic exp_err = 1'b0;
    logic exp_fd = 1'b0;
    logic [15:0] exp_burst = '0;
    logic rand_mode = 1'b0;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model: pixel k of the stream sits at x = k mod LINE_PIX, line (k / LINE_PIX) mod FRAME_LINES.
    task automatic model_push(input logic [15:0] d);
        int x;
        int y;
        pix_t p;
        x = k_model % LINE_PIX;
        y = (k_model / LINE_PIX) % FRAME_LINES;
        p.data = d;
        p.user = (x == 0) && (y == 0);
        p.last = (x == LINE_PIX - 1);
        p.fend = p.last && (y == FRAME_LINES - 1);
        exp_q.push_back(p);
        k_model++;
    endtask

    // Compare process: outputs are sampled on the falling edge, handshakes
    // seen here take effect at the following rising edge.
    always @(negedge ACLK) begin
        cyc = cyc + 1;
        if (ARESET) begin
            check("reset_outputs",
                  {S_RREADY, M_TVALID, M_TUSER, M_TLAST, M_TDATA, FRAME_DONE, RESP_ERR, BURST_CNT}, 0);
            exp_q.delete();
            k_model = 0;
            exp_err = 1'b0;
            exp_burst = '0;
            exp_fd = 1'b0;
            hold_valid = 1'b0;
            fd_count = 0;
            first_acc_cyc = -1;
            first_val_cyc = -1;
        end else begin
            if (FRAME_DONE) fd_count++;
            check("frame_done", FRAME_DONE, exp_fd);
            check("resp_err", RESP_ERR, exp_err);
            check("burst_cnt", BURST_CNT, exp_burst);
            if (hold_valid)
                check("hold_stable", {M_TVALID, M_TDATA, M_TUSER, M_TLAST},
                      {1'b1, hold_pix.data, hold_pix.user, hold_pix.last});
            exp_fd = 1'b0;
            hold_valid = 1'b0;
            if (M_TVALID) begin
                if (first_val_cyc < 0) first_val_cyc = cyc;
                check("pixel_available", exp_q.size() > 0, 1);
                if (exp_q.size() > 0)
                    check("pixel", {M_TDATA, M_TUSER, M_TLAST},
                          {exp_q[0].data, exp_q[0].user, exp_q[0].last});
                if (M_TREADY) begin
                    if (exp_q.size() > 0) begin
                        cur = exp_q.pop_front();
                        exp_fd = cur.fend;
                    end
                    got.push_back({M_TDATA, M_TUSER, M_TLAST, 1'b0});
                end else begin
                    hold_valid = 1'b1;
                    hold_pix = {M_TDATA, M_TUSER, M_TLAST, 1'b0};
                end
            end
            if (S_RVALID && S_RREADY) begin
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                model_push(S_RDATA[15:0]);
                model_push(S_RDATA[31:16]);
                if (S_RRESP != 2'b00) exp_err = 1'b1;
                if (S_RLAST) exp_burst = exp_burst + 16'd1;
            end
        end
    end

    function automatic logic [31:0] beat(input int i);
        logic [15:0] lo;
        logic [15:0] hi;
        lo = 16'(2 * i + 1);
        hi = 16'(2 * i + 2);
        return {hi, lo};
    endfunction

    task automatic wait_accept(input string name, input int limit);
        for (int i = 0; i < limit; i++) begin
            @(negedge ACLK);
            if (S_RREADY) begin
                @(posedge ACLK);
                #1;
                S_RVALID = 1'b0;
                S_RLAST = 1'b0;
                S_RRESP = 2'b00;
                return;
            end
        end
        check({name, "_accept_timeout"}, 0, 1);
        S_RVALID = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [1:0] resp, input logic last, input int limit);
        S_RDATA = d;
        S_RRESP = resp;
        S_RLAST = last;
        S_RVALID = 1'b1;
        wait_accept("beat", limit);
    endtask

    task automatic wait_pixels(input int n, input int limit);
        int i;
        i = 0;
        while (got.size() < n && i < limit) begin
            @(negedge ACLK);
            i++;
        end
        check("pixel_count_reached", got.size() >= n, 1);
    endtask

    task automatic do_reset();
        @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        S_RVALID = 1'b0;
        S_RLAST = 1'b0;
        S_RRESP = 2'b00;
        repeat (3) @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        got.delete();
        @(posedge ACLK);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        S_RDATA = '0;
        S_RRESP = 2'b00;
        S_RLAST = 1'b0;
        S_RVALID = 1'b0;
        M_TREADY = 1'b1;
        #1;
        ARESET = 1'b1;
        @(negedge ACLK);
        check("reset_tvalid", M_TVALID, 0);
        check("reset_rready", S_RREADY, 0);
        do_reset();

        // Two beats, free-running sink: pixels 1..4, one line.
        $display("test 1: basic two-beat stream");
        M_TREADY = 1'b1;
        send_beat(32'h0002_0001, 2'b00, 1'b0, 50);
        send_beat(32'h0004_0003, 2'b00, 1'b0, 50);
        wait_pixels(4, 50);
        for (int i = 0; i < 4; i++) begin
            check("t1_data", got[i].data, 16'(i + 1));
            check("t1_user", got[i].user, (i == 0));
            check("t1_last", got[i].last, (i == 3));
        end
        // Accept sampled at falling edge c precedes edge N; valid after N+2 is seen at c+3.
        check("t1_latency", first_val_cyc - first_acc_cyc, 3);

        // Two full frames with RLAST every fourth beat.
        $display("test 2: two frames, RLAST on beats 4 and 8");
        do_reset();
        for (int i = 0; i < 8; i++) send_beat(beat(i), 2'b00, (i % 4) == 3, 50);
        wait_pixels(16, 100);
        repeat (3) @(negedge ACLK);
        check("t2_frame_done_pulses", fd_count, 2);
        check("t2_burst_cnt", BURST_CNT, 16'd2);
        check("t2_user_pix1", got[0].user, 1);
        check("t2_user_pix9", got[8].user, 1);
        check("t2_user_pix5", got[4].user, 0);

        // Stalled sink: four FIFO beats plus one stage beat, then back-pressure.
        $display("test 3: back-pressure with M_TREADY low");
        do_reset();
        M_TREADY = 1'b0;
        for (int i = 0; i < 5; i++) send_beat(beat(i), 2'b00, 1'b0, 50);
        S_RDATA = beat(5);
        S_RVALID = 1'b1;
        repeat (8) @(negedge ACLK);
        check("t3_rready_low", S_RREADY, 0);
        check("t3_tvalid_held", M_TVALID, 1);
        check("t3_tdata_held", M_TDATA, 16'h0001);
        @(posedge ACLK);
        #1;
        M_TREADY = 1'b1;
        wait_accept("t3_beat6", 50);
        wait_pixels(12, 200);
        for (int i = 0; i < 12; i++) check("t3_order", got[i].data, 16'(i + 1));

        // Error response on beat 3: sticky flag, data still streamed.
        $display("test 4: SLVERR on beat 3");
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send_beat(beat(i), (i == 2) ? 2'b10 : 2'b00, 1'b0, 50);
            if (i == 1) check("t4_err_before", RESP_ERR, 0);
            if (i == 2) check("t4_err_after", RESP_ERR, 1);
        end
        wait_pixels(8, 100);
        check("t4_pix5", got[4].data, 16'h0005);
        check("t4_pix6", got[5].data, 16'h0006);
        check("t4_err_sticky", RESP_ERR, 1);

        // Reset in mid-frame discards buffered pixels and restarts framing.
        $display("test 5: reset after pixel 5");
        do_reset();
        for (int i = 0; i < 4; i++) send_beat(beat(i), 2'b00, 1'b1, 50);
        wait_pixels(5, 100);
        @(posedge ACLK);
        #1;
        ARESET = 1'b1;
        @(negedge ACLK);
        check("t5_reset_tvalid", M_TVALID, 0);
        check("t5_reset_burst", BURST_CNT, 0);
        @(posedge ACLK);
        #1;
        ARESET = 1'b0;
        got.delete();
        @(negedge ACLK);
        check("t5_rready_before_edge", S_RREADY, 0);
        @(posedge ACLK);
        #1;
        check("t5_rready_after_edge", S_RREADY, 1);
        send_beat(32'h0BBB_0AAA, 2'b00, 1'b0, 50);
        send_beat(32'h0DDD_0CCC, 2'b00, 1'b0, 50);
        wait_pixels(4, 100);
        check("t5_first_data", got[0].data, 16'h0AAA);
        check("t5_first_user", got[0].user, 1);
        check("t5_second_user", got[1].user, 0);
        check("t5_fourth_last", got[3].last, 1);

        // Random valid/ready traffic against the model.
        $display("test 6: 1000 random beats");
        do_reset();
        rand_mode = 1'b1;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    while ($urandom_range(0, 1) == 0) begin
                        @(posedge ACLK);
                        #1;
                    end
                    send_beat($urandom, 2'b00, (i % 4) == 3, 300);
                end
                rand_mode = 1'b0;
            end
            begin
                while (rand_mode) begin
                    @(posedge ACLK);
                    #1;
                    M_TREADY = 1'(($urandom_range(0, 1)));
                end
            end
        join
        M_TREADY = 1'b1;
        wait_pixels(2000, 10000);
        repeat (3) @(negedge ACLK);
        check("t6_pixel_total", got.size(), 2000);
        check("t6_model_drained", exp_q.size(), 0);
        check("t6_burst_cnt", BURST_CNT, 16'd250);
        check("t6_frames", fd_count, 250);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
